// File: rtl/scarv_cop_issue_if.sv
// Host-side and coprocessor-side handshakes of the coprocessor issuer, bundled.
// slave is the issuer's view; master is the host + coprocessor environment's view.
interface scarv_cop_issue_if;
  logic        host_req_valid;
  logic        host_req_ready;
  logic [31:0] host_req_insn;
  logic [31:0] host_req_rs1;
  logic        host_rsp_valid;
  logic        host_rsp_ready;
  logic [31:0] host_rsp_data;
  logic [4:0]  host_rsp_rd;
  logic        host_rsp_wen;
  logic        host_rsp_exc;
  logic        host_rsp_timeout;
  logic        cop_req_valid;
  logic        cop_req_ready;
  logic [31:0] cop_req_insn;
  logic [31:0] cop_req_rs1;
  logic        cop_rsp_valid;
  logic        cop_rsp_ready;
  logic [31:0] cop_rsp_data;
  logic        cop_rsp_wen;
  logic        cop_rsp_exc;

  modport slave (
    input  host_req_valid, host_req_insn, host_req_rs1, host_rsp_ready,
    input  cop_req_ready, cop_rsp_valid, cop_rsp_data, cop_rsp_wen, cop_rsp_exc,
    output host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_rd, host_rsp_wen,
    output host_rsp_exc, host_rsp_timeout, cop_req_valid, cop_req_insn, cop_req_rs1,
    output cop_rsp_ready
  );

  modport master (
    output host_req_valid, host_req_insn, host_req_rs1, host_rsp_ready,
    output cop_req_ready, cop_rsp_valid, cop_rsp_data, cop_rsp_wen, cop_rsp_exc,
    input  host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_rd, host_rsp_wen,
    input  host_rsp_exc, host_rsp_timeout, cop_req_valid, cop_req_insn, cop_req_rs1,
    input  cop_rsp_ready
  );
endinterface

// File: rtl/scarv_cop_issue.sv
// Single-outstanding coprocessor instruction issuer with local opcode precheck,
// issue/response timeout and discard of late responses after a timed-out wait.
module scarv_cop_issue #(
  parameter logic [6:0]  COP_OPCODE     = 7'b0001011,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          PRECHECK       = 1'b1
) (
  input logic              g_clk,
  input logic              g_resetn,
  scarv_cop_issue_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        stale_q, stale_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] rs1_q, rs1_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic        rsp_wen_q, rsp_wen_d;
  logic        rsp_exc_q, rsp_exc_d;
  logic        rsp_to_q, rsp_to_d;

  logic timer_hit;
  logic rsp_fire;

  // >= rather than == : a handshake on the last cycle may leave WAIT entered past the limit.
  assign timer_hit = (timer_q >= TimerLast);
  assign rsp_fire  = bus.cop_rsp_valid & bus.cop_rsp_ready;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stale_d     = stale_q;
    req_valid_d = req_valid_q;
    insn_d      = insn_q;
    rs1_d       = rs1_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_wen_d   = rsp_wen_q;
    rsp_exc_d   = rsp_exc_q;
    rsp_to_d    = rsp_to_q;

    // A response accepted while stale belongs to an abandoned request: drop it.
    if (rsp_fire && stale_q) stale_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.host_req_valid) begin
          insn_d   = bus.host_req_insn;
          rs1_d    = bus.host_req_rs1;
          rsp_rd_d = bus.host_req_insn[11:7];
          timer_d  = '0;
          if (PRECHECK && (bus.host_req_insn[6:0] != COP_OPCODE)) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_wen_d   = 1'b0;
            rsp_exc_d   = 1'b1;
            rsp_to_d    = 1'b0;
          end else begin
            state_d     = StIssue;
            req_valid_d = 1'b1;
          end
        end
      end
      StIssue: begin
        timer_d = timer_q + 16'd1;
        if (bus.cop_req_ready) begin
          state_d     = StWait;
          req_valid_d = 1'b0;
        end else if (timer_hit) begin
          state_d     = StResp;
          req_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_wen_d   = 1'b0;
          rsp_exc_d   = 1'b1;
          rsp_to_d    = 1'b1;
        end
      end
      StWait: begin
        timer_d = timer_q + 16'd1;
        if (rsp_fire && !stale_q) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.cop_rsp_data;
          rsp_wen_d   = bus.cop_rsp_wen & ~bus.cop_rsp_exc;
          rsp_exc_d   = bus.cop_rsp_exc;
          rsp_to_d    = 1'b0;
        end else if (timer_hit) begin
          state_d     = StResp;
          stale_d     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_wen_d   = 1'b0;
          rsp_exc_d   = 1'b1;
          rsp_to_d    = 1'b1;
        end
      end
      StResp: begin
        if (bus.host_rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      stale_q     <= 1'b0;
      req_valid_q <= 1'b0;
      insn_q      <= '0;
      rs1_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_wen_q   <= 1'b0;
      rsp_exc_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stale_q     <= stale_d;
      req_valid_q <= req_valid_d;
      insn_q      <= insn_d;
      rs1_q       <= rs1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_wen_q   <= rsp_wen_d;
      rsp_exc_q   <= rsp_exc_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign bus.host_req_ready   = (state_q == StIdle);
  assign bus.host_rsp_valid   = rsp_valid_q;
  assign bus.host_rsp_data    = rsp_data_q;
  assign bus.host_rsp_rd      = rsp_rd_q;
  assign bus.host_rsp_wen     = rsp_wen_q;
  assign bus.host_rsp_exc     = rsp_exc_q;
  assign bus.host_rsp_timeout = rsp_to_q;
  assign bus.cop_req_valid    = req_valid_q;
  assign bus.cop_req_insn     = insn_q;
  assign bus.cop_req_rs1      = rs1_q;
  assign bus.cop_rsp_ready    = (state_q == StWait) | stale_q;

endmodule

// File: tb/tb_scarv_cop_issue.sv
// Directed bench for scarv_cop_issue: expected host responses are queued when an
// instruction is sent and checked field by field when host_rsp_valid appears.
module tb_scarv_cop_issue;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic        exc;
    logic        to;
  } rsp_t;

  logic g_clk;
  logic g_resetn;
  int   n_cmp;
  int   n_err;
  rsp_t sb[$];

  scarv_cop_issue_if bus ();

  scarv_cop_issue #(
    .COP_OPCODE     (7'b0001011),
    .TIMEOUT_CYCLES (4),
    .PRECHECK       (1'b1)
  ) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge g_clk);
  endtask

  task automatic send(input logic [31:0] insn, input logic [31:0] rs1, input rsp_t exp);
    chk("send_req_ready", {31'd0, bus.host_req_ready}, 32'd1);
    bus.host_req_valid = 1'b1;
    bus.host_req_insn  = insn;
    bus.host_req_rs1   = rs1;
    sb.push_back(exp);
    tick();
    bus.host_req_valid = 1'b0;
    bus.host_req_insn  = 32'hFFFF_FFFF;
    bus.host_req_rs1   = 32'h0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.host_rsp_valid && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("%s_rsp_arrives", tag), {31'd0, bus.host_rsp_valid}, 32'd1);
  endtask

  // Compare the held response for hold+1 cycles, then complete the host handshake.
  task automatic rsp_check(input string tag, input int hold);
    rsp_t e;
    chk($sformatf("%s_sb_depth", tag), sb.size(), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int h = 0; h <= hold; h++) begin
      chk($sformatf("%s_valid", tag), {31'd0, bus.host_rsp_valid}, 32'd1);
      chk($sformatf("%s_data", tag), bus.host_rsp_data, e.data);
      chk($sformatf("%s_rd", tag), {27'd0, bus.host_rsp_rd}, {27'd0, e.rd});
      chk($sformatf("%s_wen", tag), {31'd0, bus.host_rsp_wen}, {31'd0, e.wen});
      chk($sformatf("%s_exc", tag), {31'd0, bus.host_rsp_exc}, {31'd0, e.exc});
      chk($sformatf("%s_timeout", tag), {31'd0, bus.host_rsp_timeout}, {31'd0, e.to});
      if (h < hold) tick();
    end
    bus.host_rsp_ready = 1'b1;
    tick();
    bus.host_rsp_ready = 1'b0;
    chk($sformatf("%s_valid_drop", tag), {31'd0, bus.host_rsp_valid}, 32'd0);
    chk($sformatf("%s_back_idle", tag), {31'd0, bus.host_req_ready}, 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    g_resetn           = 1'b0;
    bus.host_req_valid = 1'b0;
    bus.host_req_insn  = '0;
    bus.host_req_rs1   = '0;
    bus.host_rsp_ready = 1'b0;
    bus.cop_req_ready  = 1'b0;
    bus.cop_rsp_valid  = 1'b0;
    bus.cop_rsp_data   = '0;
    bus.cop_rsp_wen    = 1'b0;
    bus.cop_rsp_exc    = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_host_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd0);
    chk("rst_cop_req_valid", {31'd0, bus.cop_req_valid}, 32'd0);
    chk("rst_cop_rsp_ready", {31'd0, bus.cop_rsp_ready}, 32'd0);
    chk("rst_host_rsp_data", bus.host_rsp_data, 32'd0);
    chk("rst_cop_req_insn", bus.cop_req_insn, 32'd0);
    g_resetn = 1'b1;
    tick();
    chk("rst_req_ready", {31'd0, bus.host_req_ready}, 32'd1);

    // Minimum-latency coprocessor instruction
    bus.cop_req_ready = 1'b1;
    send(32'h0000_008B, 32'd5, rsp_t'{32'hDEAD_BEEF, 5'd1, 1'b1, 1'b0, 1'b0});
    chk("t1_cop_req_valid", {31'd0, bus.cop_req_valid}, 32'd1);
    chk("t1_cop_req_insn", bus.cop_req_insn, 32'h0000_008B);
    chk("t1_cop_req_rs1", bus.cop_req_rs1, 32'd5);
    chk("t1_req_ready_busy", {31'd0, bus.host_req_ready}, 32'd0);
    bus.cop_rsp_valid = 1'b1;
    bus.cop_rsp_data  = 32'hDEAD_BEEF;
    bus.cop_rsp_wen   = 1'b1;
    bus.cop_rsp_exc   = 1'b0;
    tick();
    chk("t1_wait_req_valid", {31'd0, bus.cop_req_valid}, 32'd0);
    chk("t1_wait_rsp_ready", {31'd0, bus.cop_rsp_ready}, 32'd1);
    chk("t1_no_early_rsp", {31'd0, bus.host_rsp_valid}, 32'd0);
    tick();
    bus.cop_rsp_valid = 1'b0;
    chk("t1_latency", {31'd0, bus.host_rsp_valid}, 32'd1);
    rsp_check("t1", 0);

    // Precheck rejects a non-coprocessor opcode
    send(32'h0000_0013, 32'h77, rsp_t'{32'd0, 5'd0, 1'b0, 1'b1, 1'b0});
    chk("t2_no_cop_req", {31'd0, bus.cop_req_valid}, 32'd0);
    chk("t2_next_cycle", {31'd0, bus.host_rsp_valid}, 32'd1);
    rsp_check("t2", 0);
    chk("t2_no_cop_req_after", {31'd0, bus.cop_req_valid}, 32'd0);

    // Coprocessor exception suppresses write-back; host stalls the response
    send(32'h0000_028B, 32'h11, rsp_t'{32'hCAFE_0001, 5'd5, 1'b0, 1'b1, 1'b0});
    bus.cop_rsp_valid = 1'b1;
    bus.cop_rsp_data  = 32'hCAFE_0001;
    bus.cop_rsp_wen   = 1'b1;
    bus.cop_rsp_exc   = 1'b1;
    wait_rsp("t3", 6);
    bus.cop_rsp_valid = 1'b0;
    bus.cop_rsp_exc   = 1'b0;
    rsp_check("t3", 2);

    // Timeout in WAIT, then a late response is discarded
    send(32'h0000_010B, 32'd7, rsp_t'{32'd0, 5'd2, 1'b0, 1'b1, 1'b1});
    repeat (3) tick();
    chk("t4_not_yet", {31'd0, bus.host_rsp_valid}, 32'd0);
    tick();
    chk("t4_timeout_at", {31'd0, bus.host_rsp_valid}, 32'd1);
    chk("t4_stale_ready", {31'd0, bus.cop_rsp_ready}, 32'd1);
    rsp_check("t4", 0);
    bus.cop_rsp_valid = 1'b1;
    bus.cop_rsp_data  = 32'h0000_1234;
    bus.cop_rsp_wen   = 1'b1;
    chk("t4_late_ready", {31'd0, bus.cop_rsp_ready}, 32'd1);
    tick();
    bus.cop_rsp_valid = 1'b0;
    chk("t4_stale_clear", {31'd0, bus.cop_rsp_ready}, 32'd0);
    chk("t4_late_dropped", {31'd0, bus.host_rsp_valid}, 32'd0);
    send(32'h0000_018B, 32'd9, rsp_t'{32'h0000_55AA, 5'd3, 1'b1, 1'b0, 1'b0});
    bus.cop_rsp_valid = 1'b1;
    bus.cop_rsp_data  = 32'h0000_55AA;
    bus.cop_rsp_wen   = 1'b1;
    wait_rsp("t4b", 6);
    bus.cop_rsp_valid = 1'b0;
    rsp_check("t4b", 0);

    // Timeout in ISSUE leaves no stale response pending
    bus.cop_req_ready = 1'b0;
    send(32'h0000_030B, 32'd1, rsp_t'{32'd0, 5'd6, 1'b0, 1'b1, 1'b1});
    wait_rsp("t6", 8);
    chk("t6_no_stale", {31'd0, bus.cop_rsp_ready}, 32'd0);
    chk("t6_req_dropped", {31'd0, bus.cop_req_valid}, 32'd0);
    rsp_check("t6", 0);

    // Request stalled 3 cycles, accepted on the last, then reset in WAIT
    bus.host_req_valid = 1'b1;
    bus.host_req_insn  = 32'h0000_020B;
    bus.host_req_rs1   = 32'hA5A5_A5A5;
    tick();
    bus.host_req_valid = 1'b0;
    bus.host_req_insn  = 32'hFFFF_FFFF;
    bus.host_req_rs1   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_req_valid", {31'd0, bus.cop_req_valid}, 32'd1);
      chk("t5_req_insn", bus.cop_req_insn, 32'h0000_020B);
      chk("t5_req_rs1", bus.cop_req_rs1, 32'hA5A5_A5A5);
      if (i == 3) bus.cop_req_ready = 1'b1;
      tick();
    end
    bus.cop_req_ready = 1'b0;
    chk("t5_in_wait", {31'd0, bus.cop_rsp_ready}, 32'd1);
    chk("t5_wait_req_valid", {31'd0, bus.cop_req_valid}, 32'd0);
    #2;
    g_resetn = 1'b0;
    #1;
    chk("t5_rst_rsp_ready", {31'd0, bus.cop_rsp_ready}, 32'd0);
    chk("t5_rst_req_valid", {31'd0, bus.cop_req_valid}, 32'd0);
    chk("t5_rst_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd0);
    chk("t5_rst_rsp_data", bus.host_rsp_data, 32'd0);
    chk("t5_rst_rsp_rd", {27'd0, bus.host_rsp_rd}, 32'd0);
    chk("t5_rst_rsp_wen", {31'd0, bus.host_rsp_wen}, 32'd0);
    chk("t5_rst_rsp_exc", {31'd0, bus.host_rsp_exc}, 32'd0);
    chk("t5_rst_rsp_timeout", {31'd0, bus.host_rsp_timeout}, 32'd0);
    chk("t5_rst_req_insn", bus.cop_req_insn, 32'd0);
    chk("t5_rst_req_rs1", bus.cop_req_rs1, 32'd0);
    tick();
    g_resetn = 1'b1;
    tick();
    chk("t5_idle_after", {31'd0, bus.host_req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_rsp", {31'd0, bus.host_rsp_valid}, 32'd0);
      tick();
    end
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
